vec_cache_write_resp_xbar: RTL and testbench

//  Return path for vector-cache writes: collects write-complete responses from the 4 cache banks and routes

---
 rtl/vec_cache_write_resp_xbar_pkg.sv | 27 ++
 rtl/vec_cache_resp_fifo.sv | 57 +++++
 rtl/vec_cache_write_resp_xbar.sv | 133 +++++++++++++
 tb/tb_vec_cache_write_resp_xbar.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_cache_write_resp_xbar_pkg.sv
// Shared types and constants for the vector-cache write-response crossbar.
package vec_cache_write_resp_xbar_pkg;

    localparam int NUM_BANKS          = 4;
    localparam int BANK_IDX_W         = 2;
    localparam int W_REQ_NUM_DFLT     = 8;
    // One bit wider than the port index so out-of-range ids can be carried and flagged.
    localparam int W_SRC_ID_WIDTH     = $clog2(W_REQ_NUM_DFLT) + 1;
    localparam int DB_ENTRY_IDX_WIDTH = 5;
    localparam int TXNID_WIDTH        = 8;
    localparam int SIDEBAND_WIDTH     = 4;

    typedef struct packed {
        logic [TXNID_WIDTH-1:0]        txnid;
        logic [SIDEBAND_WIDTH-1:0]     sideband;
        logic [W_SRC_ID_WIDTH-1:0]     src_id;
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
    } wr_resp_pld_t;

    localparam int WR_RESP_PLD_W = $bits(wr_resp_pld_t);

    // Next bank index in round-robin order; the 2-bit index wraps naturally.
    function automatic logic [BANK_IDX_W-1:0] bank_inc(input logic [BANK_IDX_W-1:0] b);
        return b + 1'b1;
    endfunction

endpackage

// File: rtl/vec_cache_resp_fifo.sv
// Valid/ready synchronous FIFO holding one bank's write responses.
module vec_cache_resp_fifo #(
    parameter int DEPTH     = 2,
    parameter int PLD_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_vld,
    output logic                 o_in_rdy,
    input  logic [PLD_WIDTH-1:0] i_in_pld,
    output logic                 o_out_vld,
    input  logic                 i_out_rdy,
    output logic [PLD_WIDTH-1:0] o_out_pld
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][PLD_WIDTH-1:0] r_mem;
    logic [PTR_W-1:0]                r_wptr;
    logic [PTR_W-1:0]                r_rptr;
    logic [CNT_W-1:0]                r_cnt;
    logic                            w_full;
    logic                            w_push;
    logic                            w_pop;

    // No pop bypass: a full FIFO stays not-ready even in the cycle it is popped.
    assign w_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_in_rdy  = !w_full && !i_rst;
    assign o_out_vld = (r_cnt != '0);
    assign o_out_pld = r_mem[r_rptr];
    assign w_push    = i_in_vld && o_in_rdy;
    assign w_pop     = o_out_vld && i_out_rdy;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_in_pld;
    end

endmodule

// File: rtl/vec_cache_write_resp_xbar.sv
// Write-response return crossbar: 4 bank FIFOs -> W_REQ_NUM write ports, round-robin per port,
// registered outputs, write-data-buffer dealloc pulses and sticky illegal-source flag.
module vec_cache_write_resp_xbar
    import vec_cache_write_resp_xbar_pkg::*;
#(
    parameter int W_REQ_NUM  = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic         [NUM_BANKS-1:0]                    i_bank_resp_vld,
    input  wr_resp_pld_t [NUM_BANKS-1:0]                    i_bank_resp_pld,
    output logic         [NUM_BANKS-1:0]                    o_bank_resp_rdy,
    output logic         [W_REQ_NUM-1:0]                    o_wr_resp_vld,
    output wr_resp_pld_t [W_REQ_NUM-1:0]                    o_wr_resp_pld,
    input  logic         [W_REQ_NUM-1:0]                    i_wr_resp_rdy,
    output logic         [NUM_BANKS-1:0]                    o_dealloc_vld,
    output logic         [NUM_BANKS-1:0][DB_ENTRY_IDX_WIDTH-1:0] o_dealloc_idx,
    output logic                                            o_err_illegal_src
);

    wr_resp_pld_t [NUM_BANKS-1:0]                 w_head;
    logic         [NUM_BANKS-1:0]                 w_head_vld;
    logic         [NUM_BANKS-1:0]                 w_illegal;
    logic         [NUM_BANKS-1:0]                 w_pop;
    logic         [W_REQ_NUM-1:0][NUM_BANKS-1:0]  w_gnt;
    logic         [W_REQ_NUM-1:0]                 w_load;
    logic         [W_REQ_NUM-1:0]                 w_load_ok;
    wr_resp_pld_t [W_REQ_NUM-1:0]                 w_sel_pld;
    logic         [W_REQ_NUM-1:0][BANK_IDX_W-1:0] w_rr_nxt;
    logic         [BANK_IDX_W-1:0]                w_idx;

    logic         [W_REQ_NUM-1:0]                 r_vld;
    wr_resp_pld_t [W_REQ_NUM-1:0]                 r_pld;
    logic         [W_REQ_NUM-1:0][BANK_IDX_W-1:0] r_rr;
    logic         [NUM_BANKS-1:0]                 r_dvld;
    logic         [NUM_BANKS-1:0][DB_ENTRY_IDX_WIDTH-1:0] r_didx;
    logic                                         r_err;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        vec_cache_resp_fifo #(
            .DEPTH     (FIFO_DEPTH),
            .PLD_WIDTH (WR_RESP_PLD_W)
        ) u_fifo (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_in_vld  (i_bank_resp_vld[b]),
            .o_in_rdy  (o_bank_resp_rdy[b]),
            .i_in_pld  (i_bank_resp_pld[b]),
            .o_out_vld (w_head_vld[b]),
            .i_out_rdy (w_pop[b]),
            .o_out_pld (w_head[b])
        );
    end

    // A head whose src_id names no port is dropped as soon as it reaches the head.
    always_comb begin
        w_illegal = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_illegal[b] = w_head_vld[b] && (int'(w_head[b].src_id) >= W_REQ_NUM);
        end
    end

    // Per-port round-robin over the bank heads addressed to it; grant only when the port register can load.
    always_comb begin
        w_gnt     = '0;
        w_load    = '0;
        w_load_ok = '0;
        w_sel_pld = '0;
        w_rr_nxt  = r_rr;
        w_idx     = '0;
        w_pop     = w_illegal;
        for (int p = 0; p < W_REQ_NUM; p++) begin
            w_load_ok[p] = !r_vld[p] || i_wr_resp_rdy[p];
            for (int k = 0; k < NUM_BANKS; k++) begin
                w_idx = r_rr[p] + BANK_IDX_W'(k);
                if (w_load_ok[p] && !w_load[p] && w_head_vld[w_idx] && !w_illegal[w_idx] &&
                    (int'(w_head[w_idx].src_id) == p)) begin
                    w_gnt[p][w_idx] = 1'b1;
                    w_load[p]       = 1'b1;
                    w_sel_pld[p]    = w_head[w_idx];
                    w_rr_nxt[p]     = bank_inc(w_idx);
                end
            end
            w_pop = w_pop | w_gnt[p];
        end
    end

    // Output registers and round-robin pointers; payload holds while valid and not accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= '0;
            r_pld <= '0;
            r_rr  <= '0;
        end else begin
            r_rr <= w_rr_nxt;
            for (int p = 0; p < W_REQ_NUM; p++) begin
                if (w_load[p]) begin
                    r_vld[p] <= 1'b1;
                    r_pld[p] <= w_sel_pld[p];
                end else if (i_wr_resp_rdy[p]) begin
                    r_vld[p] <= 1'b0;
                end
            end
        end
    end

    // Dealloc pulse for every pop, granted or dropped, one cycle after it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dvld <= '0;
            r_didx <= '0;
        end else begin
            r_dvld <= w_pop;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_pop[b]) r_didx[b] <= w_head[b].db_entry_id;
            end
        end
    end

    // Sticky error once any illegal head has been dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)           r_err <= 1'b0;
        else if (|w_illegal) r_err <= 1'b1;
    end

    assign o_wr_resp_vld     = r_vld;
    assign o_wr_resp_pld     = r_pld;
    assign o_dealloc_vld     = r_dvld;
    assign o_dealloc_idx     = r_didx;
    assign o_err_illegal_src = r_err;

endmodule

// File: tb/tb_vec_cache_write_resp_xbar.sv
// Randomized + directed bench for vec_cache_write_resp_xbar against a queue-based reference model.
module tb_vec_cache_write_resp_xbar;
    import vec_cache_write_resp_xbar_pkg::*;

    localparam int NP    = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic         [NUM_BANKS-1:0]                         bvld = '0;
    wr_resp_pld_t [NUM_BANKS-1:0]                         bpld = '0;
    logic         [NUM_BANKS-1:0]                         brdy;
    logic         [NP-1:0]                                wvld;
    wr_resp_pld_t [NP-1:0]                                wpld;
    logic         [NP-1:0]                                wrdy = '0;
    logic         [NUM_BANKS-1:0]                         dvld;
    logic         [NUM_BANKS-1:0][DB_ENTRY_IDX_WIDTH-1:0] didx;
    logic                                                 err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_cache_write_resp_xbar #(.W_REQ_NUM(NP), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_bank_resp_vld   (bvld),
        .i_bank_resp_pld   (bpld),
        .o_bank_resp_rdy   (brdy),
        .o_wr_resp_vld     (wvld),
        .o_wr_resp_pld     (wpld),
        .i_wr_resp_rdy     (wrdy),
        .o_dealloc_vld     (dvld),
        .o_dealloc_idx     (didx),
        .o_err_illegal_src (err)
    );

    // Reference model: per-bank queues, per-port output slot, round-robin start bank per port.
    wr_resp_pld_t q [NUM_BANKS][$];
    logic [NP-1:0]        m_ovld = '0;
    wr_resp_pld_t         m_opld [NP];
    int                   m_rr   [NP];
    logic [NUM_BANKS-1:0] m_dvld = '0;
    int                   m_didx [NUM_BANKS];
    bit                   m_err  = 1'b0;

    initial begin
        for (int i = 0; i < NP; i++) begin m_opld[i] = '0; m_rr[i] = 0; end
        for (int i = 0; i < NUM_BANKS; i++) m_didx[i] = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) q[b].delete();
            m_ovld = '0;
            m_dvld = '0;
            m_err  = 1'b0;
            for (int p = 0; p < NP; p++) m_rr[p] = 0;
        end else begin
            bit [NUM_BANKS-1:0] pop;
            bit [NUM_BANKS-1:0] acc;
            bit                 found;
            int                 bk;
            pop = '0;
            for (int b = 0; b < NUM_BANKS; b++) acc[b] = bvld[b] && (q[b].size() < DEPTH);
            for (int p = 0; p < NP; p++) begin
                if (!m_ovld[p] || wrdy[p]) begin
                    found = 1'b0;
                    for (int k = 0; k < NUM_BANKS; k++) begin
                        bk = (m_rr[p] + k) % NUM_BANKS;
                        if (!found && q[bk].size() > 0 && int'(q[bk][0].src_id) == p) begin
                            found     = 1'b1;
                            m_opld[p] = q[bk][0];
                            pop[bk]   = 1'b1;
                            m_rr[p]   = (bk + 1) % NUM_BANKS;
                        end
                    end
                    m_ovld[p] = found;
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (q[b].size() > 0 && int'(q[b][0].src_id) >= NP) begin
                    pop[b] = 1'b1;
                    m_err  = 1'b1;
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                m_dvld[b] = pop[b];
                if (pop[b]) begin
                    m_didx[b] = int'(q[b][0].db_entry_id);
                    void'(q[b].pop_front());
                end
                if (acc[b]) q[b].push_back(bpld[b]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic [NUM_BANKS-1:0] erdy;
        for (int b = 0; b < NUM_BANKS; b++) erdy[b] = !rst && (q[b].size() < DEPTH);
        chk("wr_resp_vld", 64'(wvld), 64'(m_ovld));
        for (int p = 0; p < NP; p++)
            if (m_ovld[p]) chk($sformatf("wr_resp_pld[%0d]", p), 64'(wpld[p]), 64'(m_opld[p]));
        chk("bank_resp_rdy", 64'(brdy), 64'(erdy));
        chk("dealloc_vld", 64'(dvld), 64'(m_dvld));
        for (int b = 0; b < NUM_BANKS; b++)
            if (m_dvld[b]) chk($sformatf("dealloc_idx[%0d]", b), 64'(didx[b]), 64'(m_didx[b]));
        chk("err_illegal_src", 64'(err), 64'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    function automatic wr_resp_pld_t mk(input int txn, input int src, input int db);
        wr_resp_pld_t r;
        r.txnid       = TXNID_WIDTH'(txn);
        r.sideband    = SIDEBAND_WIDTH'(txn >> 2);
        r.src_id      = W_SRC_ID_WIDTH'(src);
        r.db_entry_id = DB_ENTRY_IDX_WIDTH'(db);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bvld = '0;
        #1;
        cmp_all();
        chk("rst_wr_vld", 64'(wvld), 64'h0);
        chk("rst_bank_rdy", 64'(brdy), 64'h0);
        chk("rst_dealloc", 64'(dvld), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("post_rst_bank_rdy", 64'(brdy), 64'hF);
    endtask

    initial begin
        wrdy = '1;
        repeat (2) @(negedge clk);
        do_reset();

        // Single response: bank 2 -> port 5, db 7.
        bvld[2] = 1'b1; bpld[2] = mk(8'h5A, 5, 7);
        cyc();
        chk("t1_not_yet", 64'(wvld), 64'h0);
        bvld = '0;
        cyc();
        chk("t1_vld", 64'(wvld), 64'h20);
        chk("t1_txn", 64'(wpld[5].txnid), 64'h5A);
        chk("t1_dvld", 64'(dvld), 64'h4);
        chk("t1_didx", 64'(didx[2]), 64'd7);
        cyc();
        chk("t1_drain", 64'({wvld, dvld}), 64'h0);

        // Contention: all banks to port 3, twice; order restarts at bank 0.
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin bvld[b] = 1'b1; bpld[b] = mk(b, 3, 10 + b); end
            cyc();
            bvld = '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                cyc();
                chk("t2_vld3", 64'(wvld[3]), 64'h1);
                chk("t2_order", 64'(wpld[3].txnid), 64'(i));
            end
        end
        cyc();

        // Parallel: bank b -> port b.
        for (int b = 0; b < NUM_BANKS; b++) begin bvld[b] = 1'b1; bpld[b] = mk(32 + b, b, b); end
        cyc();
        bvld = '0;
        cyc();
        chk("t4_vld", 64'(wvld), 64'h0F);
        chk("t4_dvld", 64'(dvld), 64'hF);
        cyc();

        // Backpressure on port 1: 1 in output reg + 2 in FIFO, then drain in order.
        wrdy[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bvld[0] = 1'b1; bpld[0] = mk(10 + i, 1, 20 + i);
            cyc();
        end
        bvld = '0;
        chk("t3_full", 64'(brdy[0]), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_hold", 64'(wpld[1].txnid), 64'd10);
        end
        wrdy[1] = 1'b1;
        for (int i = 1; i < 3; i++) begin
            cyc();
            chk("t3_drain", 64'(wpld[1].txnid), 64'(10 + i));
        end
        cyc();
        chk("t3_empty", 64'(wvld[1]), 64'h0);

        // Illegal source id: dropped, dealloc still issued, sticky error.
        bvld[1] = 1'b1; bpld[1] = mk(8'h33, 9, 20);
        cyc();
        bvld = '0;
        cyc();
        chk("t5_no_vld", 64'(wvld), 64'h0);
        chk("t5_dvld", 64'(dvld), 64'h2);
        chk("t5_didx", 64'(didx[1]), 64'd20);
        chk("t5_err", 64'(err), 64'h1);
        repeat (3) cyc();
        chk("t5_sticky", 64'(err), 64'h1);
        do_reset();

        // Random traffic, occasional illegal ids.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bvld[b] = ($urandom_range(0, 2) != 0);
                bpld[b] = mk($urandom_range(0, 255),
                             ($urandom_range(0, 31) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 3) * 2 + b % 2,
                             $urandom_range(0, 31));
            end
            for (int p = 0; p < NP; p++) wrdy[p] = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bvld = '0;
        wrdy = '1;
        repeat (4) cyc();

        // Reset while FIFOs hold entries: nothing delivered or deallocated afterwards.
        wrdy = '0;
        for (int i = 0; i < 3; i++) begin
            bvld = 4'b0011; bpld[0] = mk(i, 2, i); bpld[1] = mk(8 + i, 2, 8 + i);
            cyc();
        end
        bvld = '0;
        #1;
        rst = 1'b1;
        #1;
        cmp_all();
        chk("t6_vld", 64'(wvld), 64'h0);
        chk("t6_dvld", 64'(dvld), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        wrdy = '1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t6_quiet", 64'({wvld, dvld}), 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
